// File: rtl/slc3_mem_responder.sv
// rtl/slc3_mem_responder.sv - one BRAM access per Mem_OE/Mem_WE strobe, plus I/O word decode
module slc3_mem_responder #(
    parameter int          DATA_W   = 16,
    parameter int          BRAM_AW  = 10,
    parameter int          READ_LAT = 2,
    parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Mem_OE,
    input  logic               Mem_WE,
    input  logic [15:0]        ADDR,
    input  logic [DATA_W-1:0]  Data_from_CPU,
    output logic [DATA_W-1:0]  Data_to_CPU,
    output logic               Data_valid,
    input  logic [DATA_W-1:0]  SW,
    output logic [DATA_W-1:0]  HEX_out,
    output logic               bram_en,
    output logic               bram_we,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [DATA_W-1:0]  bram_din,
    input  logic [DATA_W-1:0]  bram_dout
);

    typedef enum logic [1:0] {IDLE, RD_LAT, RD_HOLD, WR_HOLD} state_t;

    localparam logic [1:0] CNT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic              io_sel;
    logic              rd_first;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rd_word;
    logic              is_io;

    assign is_io     = (ADDR == IO_ADDR);
    assign bram_addr = ADDR[BRAM_AW-1:0];
    assign bram_din  = Data_from_CPU;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath registers; rd_first marks the single cycle in which read data is captured.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= 2'd0;
            io_sel   <= 1'b0;
            rd_first <= 1'b0;
            rdata_q  <= '0;
            HEX_out  <= '0;
        end else begin
            rd_first <= (state_nxt == RD_HOLD) && (state != RD_HOLD);
            case (state)
                IDLE: begin
                    if (Mem_WE) begin
                        if (is_io) HEX_out <= Data_from_CPU;
                    end else if (Mem_OE) begin
                        io_sel <= is_io;
                        cnt    <= CNT_INIT;
                    end
                end
                RD_LAT:  cnt <= cnt - 2'd1;
                RD_HOLD: if (rd_first) rdata_q <= rd_word;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Mem_WE)      state_nxt = WR_HOLD;
                else if (Mem_OE) state_nxt = (READ_LAT == 1) ? RD_HOLD : RD_LAT;
            end
            RD_LAT: begin
                if (!Mem_OE || Mem_WE) state_nxt = IDLE;
                else if (cnt == 2'd0)  state_nxt = RD_HOLD;
            end
            RD_HOLD: if (!Mem_OE || Mem_WE) state_nxt = IDLE;
            WR_HOLD: if (!Mem_WE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        Data_valid  = 1'b0;
        Data_to_CPU = '0;
        rd_word     = io_sel ? SW : bram_dout;
        if (!Reset) begin
            case (state)
                IDLE: begin
                    if (Mem_WE) begin
                        bram_en = !is_io;
                        bram_we = !is_io;
                    end else if (Mem_OE) begin
                        bram_en = 1'b1;
                    end
                end
                RD_LAT: bram_en = 1'b1;
                RD_HOLD: begin
                    Data_valid  = Mem_OE;
                    Data_to_CPU = rd_first ? rd_word : rdata_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb/tb_slc3_mem_responder.sv - scoreboard bench for slc3_mem_responder with a behavioural BRAM
module tb_slc3_mem_responder;

    localparam int          LAT = 2;
    localparam logic [15:0] IO  = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset, Mem_OE, Mem_WE;
    logic [15:0] ADDR, Data_from_CPU, Data_to_CPU, SW, HEX_out, bram_din, bram_dout;
    logic        Data_valid, bram_en, bram_we;
    logic [9:0]  bram_addr;

    slc3_mem_responder #(.DATA_W(16), .BRAM_AW(10), .READ_LAT(LAT), .IO_ADDR(IO)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Data_valid(Data_valid),
        .SW(SW), .HEX_out(HEX_out), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 Clk = ~Clk;

    // Two-stage BRAM: address register then output register, both gated by enable.
    logic [15:0] bram [1024];
    logic [9:0]  addr_q;
    logic [15:0] dout_q;
    always @(posedge Clk) begin
        if (bram_en) begin
            if (bram_we) bram[bram_addr] <= bram_din;
            addr_q <= bram_addr;
            dout_q <= bram[addr_q];
        end
    end
    assign bram_dout = dout_q;

    logic [15:0] ref_mem [1024];
    logic [15:0] hex_exp = 16'h0;
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count consecutive read-strobe cycles; valid must appear exactly at LAT.
    int          oe_run = 0;
    int          cur;
    logic [15:0] held;
    always @(negedge Clk) begin
        if (Reset) begin
            oe_run = 0;
        end else begin
            if (Mem_OE && !Mem_WE) begin
                cur = oe_run;
                oe_run++;
            end else begin
                cur = -1;
                oe_run = 0;
            end
            if (cur >= LAT) begin
                check("data_valid_high", {31'd0, Data_valid}, 32'd1);
                if (cur == LAT) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: got read data %h expected no read", Data_to_CPU);
                        held = 16'hxxxx;
                    end else begin
                        held = exp_q.pop_front();
                    end
                end
                check("read_data", {16'd0, Data_to_CPU}, {16'd0, held});
            end else begin
                check("data_valid_low", {31'd0, Data_valid}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        ADDR = a; Mem_OE = 1'b1; Mem_WE = 1'b0; Data_from_CPU = 16'($urandom);
        if (n > LAT) exp_q.push_back((a == IO) ? SW : ref_mem[a[9:0]]);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (i == LAT) SW = 16'($urandom);
        end
        Mem_OE = 1'b0;
        cyc();
        @(negedge Clk);
        check("idle_bram_en", {31'd0, bram_en}, 32'd0);
        check("idle_data_to_cpu", {16'd0, Data_to_CPU}, 32'd0);
        cyc();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int n, input logic oe);
        int pulses;
        pulses = 0;
        ADDR = a; Data_from_CPU = d; Mem_WE = 1'b1; Mem_OE = oe;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (bram_we === 1'b1) pulses++;
            cyc();
        end
        Mem_WE = 1'b0; Mem_OE = 1'b0;
        @(negedge Clk);
        if (bram_we === 1'b1) pulses++;
        cyc();
        if (a == IO) hex_exp = d;
        else         ref_mem[a[9:0]] = d;
        check("write_pulses", pulses, (a == IO) ? 32'd0 : 32'd1);
        check("hex_out", {16'd0, HEX_out}, {16'd0, hex_exp});
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return IO;
            1:       return 16'($urandom_range(0, 31));
            2:       return 16'($urandom);
            default: return 16'($urandom_range(0, 31)) | (16'($urandom_range(1, 63)) << 10);
        endcase
    endfunction

    initial begin
        logic [15:0] v;
        Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0;
        Data_from_CPU = 16'h0; SW = 16'h0;
        for (int i = 0; i < 1024; i++) begin
            v = 16'($urandom);
            bram[i] = v;
            ref_mem[i] = v;
        end
        cyc();
        Mem_OE = 1'b1; ADDR = 16'h0010;
        @(negedge Clk);
        check("rst_bram_en", {31'd0, bram_en}, 32'd0);
        check("rst_bram_we", {31'd0, bram_we}, 32'd0);
        check("rst_valid", {31'd0, Data_valid}, 32'd0);
        check("rst_data", {16'd0, Data_to_CPU}, 32'd0);
        check("rst_hex", {16'd0, HEX_out}, 32'd0);

        // Reset pulse while the read sits in its latency state
        cyc(); Reset = 1'b0;
        cyc(); Reset = 1'b1; Mem_OE = 1'b0;
        @(negedge Clk);
        check("midrd_valid", {31'd0, Data_valid}, 32'd0);
        check("midrd_hex", {16'd0, HEX_out}, 32'd0);
        check("midrd_bram_en", {31'd0, bram_en}, 32'd0);
        cyc(); Reset = 1'b0;
        cyc();
        do_read(16'h0010, 3);

        bram[5] = 16'h1234; ref_mem[5] = 16'h1234;
        do_read(16'h0005, 3);

        do_write(16'h0020, 16'hBEEF, 3, 1'b1);
        do_read(16'h0020, 3);

        SW = 16'h00A5; bram[10'h3FF] = 16'h5A5A; ref_mem[10'h3FF] = 16'h5A5A;
        do_read(IO, 4);
        do_write(IO, 16'h0C3F, 3, 1'b0);

        do_read(16'h0007, 1);
        do_read(16'h0007, 2);
        do_read(16'h0007, 3);

        do_write(16'h0405, 16'h7777, 2, 1'b0);
        do_read(16'h0005, 3);

        for (int t = 0; t < 300; t++) begin
            SW = 16'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_write(pick_addr(), 16'($urandom), $urandom_range(1, 4), 1'($urandom));
            else
                do_read(pick_addr(), $urandom_range(1, 6));
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
